// File: rtl/udma_adc_rx_seq.sv
// udma_adc_rx_seq: scans enabled ADC channels, buffers tagged samples and emits them as level-stretched valids.
// Define UDMA_ADC_RX_SEQ_TIMESTAMP_EN to stamp a free-running counter into the bits between sample and channel ID.
module udma_adc_rx_seq #(
    parameter int ADC_NUM_CHS    = 8,
    parameter int CH_ID_WIDTH    = 4,
    parameter int CH_ID_LSB      = 28,
    parameter int ADC_DATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH   = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int HOLD_CYCLES    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cfg_en_i,
    input  logic [ADC_NUM_CHS-1:0]    cfg_ch_mask_i,
    input  logic [15:0]               cfg_period_i,
    output logic                      adc_start_o,
    output logic [CH_ID_WIDTH-1:0]    adc_ch_o,
    input  logic                      adc_done_i,
    input  logic [SAMPLE_WIDTH-1:0]   adc_sample_i,
    output logic                      adc_rx_valid_o,
    output logic [ADC_DATA_WIDTH-1:0] adc_rx_data_o,
    output logic                      overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES);

    typedef enum logic [1:0] {IDLE, START, CONV, WAIT} scan_e;
    typedef enum logic [1:0] {OIDLE, OHIGH, OLOW} out_e;

    scan_e                     st_q;
    out_e                      ost_q;
    logic                      start_q, valid_q, ovf_q;
    logic [CH_ID_WIDTH-1:0]    ch_q, first_ch, next_ch;
    logic                      next_hit, any_ch, period_hit, push, pop, full, wr_en;
    logic [15:0]               cnt_q;
    logic [ADC_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wr_q, rd_q;
    logic [AW:0]               fill_q;
    logic [ADC_DATA_WIDTH-1:0] data_q, word_d;
    logic [HW-1:0]             hold_q;

    assign any_ch     = |cfg_ch_mask_i;
    assign period_hit = ({1'b0, cnt_q} + 17'd1) >= {1'b0, cfg_period_i};
    assign push       = (st_q == CONV) && adc_done_i;
    assign pop        = (ost_q == OIDLE) && (fill_q != '0);
    assign full       = fill_q == (AW+1)'(FIFO_DEPTH);
    assign wr_en      = push && (!full || pop);

    // Walk downward so the lowest qualifying bit wins.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        next_hit = 1'b0;
        for (int i = ADC_NUM_CHS - 1; i >= 0; i--) begin
            if (cfg_ch_mask_i[i]) first_ch = CH_ID_WIDTH'(i);
            if (cfg_ch_mask_i[i] && i > int'(ch_q)) begin
                next_ch  = CH_ID_WIDTH'(i);
                next_hit = 1'b1;
            end
        end
    end

`ifdef UDMA_ADC_RX_SEQ_TIMESTAMP_EN
    logic [CH_ID_LSB-SAMPLE_WIDTH-1:0] ts_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ts_q <= '0;
        else         ts_q <= ts_q + 1'b1;
    end
`endif

    always_comb begin
        word_d = '0;
        word_d[CH_ID_LSB +: CH_ID_WIDTH]  = ch_q;
        word_d[SAMPLE_WIDTH-1:0]          = adc_sample_i;
`ifdef UDMA_ADC_RX_SEQ_TIMESTAMP_EN
        word_d[CH_ID_LSB-1:SAMPLE_WIDTH]  = ts_q;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q    <= IDLE;
            start_q <= 1'b0;
            ch_q    <= '0;
            cnt_q   <= '0;
        end else begin
            start_q <= 1'b0;
            if (cnt_q != '1) cnt_q <= cnt_q + 16'd1;
            case (st_q)
                IDLE: if (cfg_en_i && any_ch) begin
                    st_q    <= START;
                    start_q <= 1'b1;
                    ch_q    <= first_ch;
                    cnt_q   <= '0;
                end
                START: st_q <= cfg_en_i ? CONV : IDLE;
                CONV: if (adc_done_i) begin
                    if (!cfg_en_i || !any_ch) st_q <= IDLE;
                    else if (next_hit) begin
                        st_q    <= START;
                        start_q <= 1'b1;
                        ch_q    <= next_ch;
                    end else st_q <= WAIT;
                end
                WAIT: if (!cfg_en_i) st_q <= IDLE;
                else if (period_hit) begin
                    if (!any_ch) st_q <= IDLE;
                    else begin
                        st_q    <= START;
                        start_q <= 1'b1;
                        ch_q    <= first_ch;
                        cnt_q   <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q] <= word_d;
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            fill_q <= fill_q + (AW+1)'(wr_en) - (AW+1)'(pop);
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ost_q   <= OIDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            hold_q  <= '0;
        end else begin
            case (ost_q)
                OIDLE: if (pop) begin
                    data_q  <= mem_q[rd_q];
                    valid_q <= 1'b1;
                    hold_q  <= '0;
                    ost_q   <= OHIGH;
                end
                OHIGH: begin
                    hold_q <= hold_q + 1'b1;
                    if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        hold_q  <= '0;
                        valid_q <= 1'b0;
                        ost_q   <= OLOW;
                    end
                end
                OLOW: begin
                    hold_q <= hold_q + 1'b1;
                    if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        hold_q <= '0;
                        ost_q  <= OIDLE;
                    end
                end
                default: ost_q <= OIDLE;
            endcase
        end
    end

    assign adc_start_o    = start_q;
    assign adc_ch_o       = ch_q;
    assign adc_rx_valid_o = valid_q;
    assign adc_rx_data_o  = data_q;
    assign overflow_o     = ovf_q;
endmodule

// File: tb/tb_udma_adc_rx_seq.sv
// tb_udma_adc_rx_seq: randomized and directed checks of udma_adc_rx_seq against a queue-based model.
module tb_udma_adc_rx_seq;
    localparam int H = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b0;
    logic [7:0]  cfg_mask = '0;
    logic [15:0] cfg_period = '0;
    logic        adc_start;
    logic [3:0]  adc_ch;
    logic        adc_done = 1'b0;
    logic [15:0] adc_sample = '0;
    logic        adc_rx_valid;
    logic [31:0] adc_rx_data;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    udma_adc_rx_seq dut (
        .clk_i(clk), .rst_ni(rst_n), .cfg_en_i(cfg_en), .cfg_ch_mask_i(cfg_mask),
        .cfg_period_i(cfg_period), .adc_start_o(adc_start), .adc_ch_o(adc_ch),
        .adc_done_i(adc_done), .adc_sample_i(adc_sample), .adc_rx_valid_o(adc_rx_valid),
        .adc_rx_data_o(adc_rx_data), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int nxt_ch(input logic [7:0] m, input int last);
        for (int i = 0; i < 8; i++) if (m[i] && i > last) return i;
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return -1;
    endfunction

    // ADC stand-in: answers each start with a done pulse dly cycles later.
    int dly = 5;
    bit fixed_samples = 0;
    int stray_n = 0;
    initial begin
        int cd, nsamp, stray_seen;
        bit pend;
        logic [15:0] tbl [3];
        tbl = '{16'h1111, 16'h2222, 16'h3333};
        pend = 0; cd = 0; nsamp = 0; stray_seen = 0;
        forever begin
            @(posedge clk);
            #1;
            adc_done = 1'b0;
            if (!rst_n) begin
                pend = 0;
                nsamp = 0;
            end else begin
                if (pend) begin
                    cd--;
                    if (cd == 0) begin
                        adc_done = 1'b1;
                        adc_sample = (fixed_samples && nsamp < 3) ? tbl[nsamp] : 16'($urandom);
                        nsamp++;
                        pend = 0;
                    end
                end
                if (adc_start) begin
                    pend = 1;
                    cd = dly;
                end
                if (stray_seen != stray_n) begin
                    stray_seen = stray_n;
                    adc_done = 1'b1;
                    adc_sample = 16'($urandom);
                end
            end
        end
    end

    // Behavioural model and per-cycle compare.
    int st_t[$], st_ch[$], rise_t[$], fall_t[$];
    logic [31:0] outs[$];
    initial begin
        logic [31:0] fq[$];
        logic [31:0] m_data, w;
        logic [11:0] ts;
        bit m_ovf, awaiting, pop, push, prev_v;
        int ph, last_ch, cur_ch, cyc, e;
        ph = 0; m_data = 0; m_ovf = 0; awaiting = 0; last_ch = -1; cur_ch = 0; cyc = 0; ts = 0; prev_v = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                fq.delete();
                ph = 0; m_data = 0; m_ovf = 0; awaiting = 0; last_ch = -1; ts = 0; prev_v = 0;
            end else begin
                chk("valid", 32'(adc_rx_valid), 32'(ph >= 1 && ph <= H));
                chk("data", adc_rx_data, m_data);
                chk("overflow", 32'(overflow), 32'(m_ovf));
                if (adc_rx_valid && !prev_v) begin
                    rise_t.push_back(cyc);
                    outs.push_back(adc_rx_data);
                end
                if (!adc_rx_valid && prev_v) fall_t.push_back(cyc);
                prev_v = adc_rx_valid;
                pop = (ph == 0) && (fq.size() > 0);
                push = adc_done && awaiting;
                w = {4'(cur_ch), 12'h000, adc_sample};
`ifdef UDMA_ADC_RX_SEQ_TIMESTAMP_EN
                w[27:16] = ts;
`endif
                if (pop) m_data = fq.pop_front();
                if (push) begin
                    if (fq.size() < DEPTH) fq.push_back(w);
                    else m_ovf = 1;
                    awaiting = 0;
                end
                ph = pop ? 1 : (ph == 0 || ph == 2 * H) ? 0 : ph + 1;
                if (adc_start) begin
                    e = nxt_ch(cfg_mask, last_ch);
                    chk("start_ch", 32'(adc_ch), 32'(e));
                    cur_ch = e;
                    last_ch = e;
                    awaiting = 1;
                    st_t.push_back(cyc);
                    st_ch.push_back(e);
                end
                if (!cfg_en) last_ch = -1;
                ts++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step(1);
        rst_n = 1'b0;
        cfg_en = 1'b0;
        fixed_samples = 0;
        step(3);
        chk("rst_start", 32'(adc_start), 0);
        chk("rst_ch", 32'(adc_ch), 0);
        chk("rst_valid", 32'(adc_rx_valid), 0);
        chk("rst_data", adc_rx_data, 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
    endtask

    task automatic drop_en();
        if (adc_start) step(1);
        cfg_en = 1'b0;
    endtask

    task automatic wait_start(input int ch, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            step(1);
            if (adc_start && adc_ch == 4'(ch)) break;
        end
        chk("wait_start", 32'(k < budget), 1);
    endtask

    task automatic wait_valid(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            step(1);
            if (adc_rx_valid) break;
        end
        chk("wait_valid", 32'(k < budget), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sb, ob, rb, fb, n0;
        logic [31:0] o0, o1;
        // Scan order, tagging and output timing with a 100-cycle period.
        do_reset();
        cfg_mask = 8'b0010_0101; cfg_period = 16'd100; dly = 5; fixed_samples = 1;
        sb = st_t.size(); ob = outs.size(); rb = rise_t.size(); fb = fall_t.size();
        cfg_en = 1'b1;
        step(260);
        drop_en();
        step(40);
        chk("scan_ch0", 32'(st_ch[sb]), 0);
        chk("scan_ch1", 32'(st_ch[sb+1]), 2);
        chk("scan_ch2", 32'(st_ch[sb+2]), 5);
        chk("rescan_ch", 32'(st_ch[sb+3]), 0);
        chk("period_gap1", 32'(st_t[sb+3] - st_t[sb]), 100);
        chk("period_gap2", 32'(st_t[sb+6] - st_t[sb+3]), 100);
        chk("word0", outs[ob] & 32'hF000_FFFF, 32'h0000_1111);
        chk("word1", outs[ob+1] & 32'hF000_FFFF, 32'h2000_2222);
        chk("word2", outs[ob+2] & 32'hF000_FFFF, 32'h5000_3333);
        chk("high_len", 32'(fall_t[fb] - rise_t[rb]), 4);
        chk("spacing", 32'(rise_t[rb+1] - rise_t[rb]), 9);

        // Overflow: all channels, fast conversions, short period.
        do_reset();
        cfg_mask = 8'hFF; cfg_period = 16'd10; dly = 1;
        ob = outs.size();
        cfg_en = 1'b1;
        step(30);
        chk("ovf_set", 32'(overflow), 1);
        step(100);
        drop_en();
        step(80);
        chk("ovf_sticky", 32'(overflow), 1);
        for (int k = 0; k < 4; k++) begin
            o0 = outs[ob+k];
            chk("ovf_order", 32'(o0[31:28]), 32'(k));
        end

        // Disable during conversion: sample still delivered, no further starts.
        do_reset();
        cfg_mask = 8'b0010_0101; cfg_period = 16'd100; dly = 5;
        ob = outs.size();
        cfg_en = 1'b1;
        wait_start(2, 50);
        step(2);
        cfg_en = 1'b0;
        n0 = st_t.size();
        step(150);
        chk("no_start_after_dis", 32'(st_t.size()), 32'(n0));
        chk("dis_outputs", 32'(outs.size() - ob), 2);
        o0 = outs[ob+1];
        chk("dis_last_ch", 32'(o0[31:28]), 2);
        cfg_en = 1'b1;
        step(3);
        chk("reen_start", 32'(st_t.size()), 32'(n0 + 1));
        chk("reen_ch", 32'(st_ch[st_ch.size()-1]), 0);
        drop_en();
        step(60);

        // Reset while valid is high, then stray done while idle.
        do_reset();
        cfg_mask = 8'h01; cfg_period = 16'd50; dly = 3;
        cfg_en = 1'b1;
        wait_valid(50);
        step(1);
        rst_n = 1'b0;
        cfg_en = 1'b0;
        #1;
        chk("async_valid_drop", 32'(adc_rx_valid), 0);
        step(2);
        rst_n = 1'b1;
        ob = outs.size();
        step(5);
        stray_n++;
        step(35);
        chk("quiet_after_rst", 32'(outs.size() - ob), 0);
        cfg_en = 1'b1;
        step(30);
        chk("out_after_rescan", 32'(outs.size() - ob), 1);
        drop_en();
        step(20);

`ifdef UDMA_ADC_RX_SEQ_TIMESTAMP_EN
        do_reset();
        cfg_mask = 8'h01; cfg_period = 16'd37; dly = 5;
        ob = outs.size();
        cfg_en = 1'b1;
        step(120);
        drop_en();
        step(40);
        o0 = outs[ob];
        o1 = outs[ob+1];
        chk("ts_delta", 32'(12'(o1[27:16] - o0[27:16])), 37);
`endif

        // Randomized scans.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            cfg_mask = 8'($urandom_range(1, 255));
            cfg_period = 16'($urandom_range(5, 60));
            dly = $urandom_range(1, 8);
            cfg_en = 1'b1;
            step(300);
            drop_en();
            step(100);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
